// File: rtl/regfile_pkg.sv
// Shared widths, the zero-register index and the writeback priority type.
package regfile_pkg;

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned ADDR_W   = 5;
  localparam int unsigned NUM_REGS = 2 ** ADDR_W;

  localparam logic [ADDR_W-1:0] REG_ZERO = '0;

  typedef enum logic {
    PRIO_A = 1'b0,
    PRIO_B = 1'b1
  } prio_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: combinational grant, the loser of the last grant is favoured next.
// req[0]/gnt[0] is the ALU requester, req[1]/gnt[1] the load requester.
module rr_arb2
  import regfile_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  prio_t prio_q, prio_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prio_q <= PRIO_A;
    end else begin
      prio_q <= prio_d;
    end
  end

  always_comb begin
    gnt    = 2'b00;
    prio_d = prio_q;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = (prio_q == PRIO_A) ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
    // Hand priority to whoever did not win; idle cycles leave it alone.
    if (gnt[0]) begin
      prio_d = PRIO_B;
    end else if (gnt[1]) begin
      prio_d = PRIO_A;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Owns the register-file write port: arbitrates ALU/load writebacks into a one-cycle registered write,
// and tracks claimed destinations so readers stall until the pending write has landed.
module regfile_wb_arbiter
  import regfile_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              claim_valid,
  input  logic [ADDR_W-1:0] claim_reg,
  input  logic              a_valid,
  input  logic [ADDR_W-1:0] a_reg,
  input  logic [DATA_W-1:0] a_data,
  output logic              a_ready,
  input  logic              b_valid,
  input  logic [ADDR_W-1:0] b_reg,
  input  logic [DATA_W-1:0] b_data,
  output logic              b_ready,
  input  logic [ADDR_W-1:0] query_reg1,
  input  logic [ADDR_W-1:0] query_reg2,
  output logic              stall,
  output logic              reg_write,
  output logic [ADDR_W-1:0] write_reg,
  output logic [DATA_W-1:0] write_data,
  output logic              claim_err
);

  logic [1:0]          req;
  logic [1:0]          gnt;
  logic                xfer;
  logic [ADDR_W-1:0]   sel_reg;
  logic [DATA_W-1:0]   sel_data;
  logic                claim_live;
  logic                clear_hit;

  logic                reg_write_q,  reg_write_d;
  logic [ADDR_W-1:0]   write_reg_q,  write_reg_d;
  logic [DATA_W-1:0]   write_data_q, write_data_d;
  logic [NUM_REGS-1:0] busy_q,       busy_d;
  logic                claim_err_q,  claim_err_d;

  // Nothing is accepted while in reset, so no requester loses a write to it.
  assign req = {b_valid, a_valid} & {2{rst_n}};

  rr_arb2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .gnt   (gnt)
  );

  assign a_ready  = gnt[0];
  assign b_ready  = gnt[1];
  assign xfer     = |gnt;
  assign sel_reg  = gnt[1] ? b_reg  : a_reg;
  assign sel_data = gnt[1] ? b_data : a_data;

  assign claim_live = claim_valid && (claim_reg != REG_ZERO);
  assign clear_hit  = reg_write_q && (write_reg_q == claim_reg);

  always_comb begin
    reg_write_d  = xfer && (sel_reg != REG_ZERO);
    write_reg_d  = write_reg_q;
    write_data_d = write_data_q;
    if (xfer) begin
      write_reg_d  = sel_reg;
      write_data_d = sel_data;
    end

    busy_d      = busy_q;
    claim_err_d = claim_err_q;
    if (reg_write_q) begin
      busy_d[write_reg_q] = 1'b0;
    end
    // A claim landing on the write being retired is a legal re-claim, not a double claim.
    if (claim_live) begin
      if (busy_q[claim_reg] && !clear_hit) begin
        claim_err_d = 1'b1;
      end
      busy_d[claim_reg] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      reg_write_q  <= 1'b0;
      write_reg_q  <= '0;
      write_data_q <= '0;
      busy_q       <= '0;
      claim_err_q  <= 1'b0;
    end else begin
      reg_write_q  <= reg_write_d;
      write_reg_q  <= write_reg_d;
      write_data_q <= write_data_d;
      busy_q       <= busy_d;
      claim_err_q  <= claim_err_d;
    end
  end

  assign stall = ((query_reg1 != REG_ZERO) && busy_q[query_reg1]) ||
                 ((query_reg2 != REG_ZERO) && busy_q[query_reg2]);

  assign reg_write  = reg_write_q;
  assign write_reg  = write_reg_q;
  assign write_data = write_data_q;
  assign claim_err  = claim_err_q;

endmodule
